// File: rtl/load_align_unit.sv
// Load-data path for the memory stage: captures one load request, issues one or two aligned
// bus reads, right-justifies the addressed bytes and zero/sign-extends them into a result
// returned over a valid/ready handshake.
//
// req_msize_i encoding: 2'd0 = 1 byte, 2'd1 = 2 bytes, 2'd2 = 4 bytes, 2'd3 = 8 bytes.
module load_align_unit #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned ADDR_W      = 64,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_msize_i,
    input  logic              req_unsigned_i,
    output logic              dreq_valid_o,
    output logic [ADDR_W-1:0] dreq_addr_o,
    input  logic              dresp_data_ok_i,
    input  logic [DATA_W-1:0] dresp_data_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_error_o
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        msize_q, msize_d;
    logic              uns_q, uns_d;
    logic              split_q, split_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] dreq_addr_q, dreq_addr_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_error_q, resp_error_d;

    logic [OFF_W-1:0]    req_off;
    logic [3:0]          req_nbytes;
    logic [4:0]          req_end;
    logic                req_size_err;
    logic                req_align_err;
    logic                req_split;
    logic [ADDR_W-1:0]   req_base;

    logic [2*DATA_W-1:0] merge_w;
    logic [DATA_W-1:0]   merge_sh;
    logic [DATA_W-1:0]   merged;
    logic [3:0]          cur_nbytes;
    logic                sgn;

    // Decode the incoming request: byte count, errors, and whether it crosses a bus word.
    always_comb begin
        req_off       = req_addr_i[OFF_W-1:0];
        req_nbytes    = 4'd1 << req_msize_i;
        req_end       = 5'(req_off) + 5'(req_nbytes);
        req_size_err  = 32'(req_nbytes) > BYTES;
        req_align_err = !MISALIGN_EN && ((4'(req_off) & (req_nbytes - 4'd1)) != 4'd0);
        req_split     = req_end > 5'(BYTES);
        req_base      = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Merge the beat(s), shift the addressed bytes down and extend to the full width.
    always_comb begin
        if (state_q == StBeat1) begin
            merge_w = {dresp_data_i, lo_q};
        end else begin
            merge_w = {{DATA_W{1'b0}}, dresp_data_i};
        end
        merge_sh   = DATA_W'(merge_w >> {off_q, 3'b000});
        cur_nbytes = 4'd1 << msize_q;
        sgn        = 1'b0;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (4'(i + 1) == cur_nbytes) begin
                sgn = merge_sh[8*i+7];
            end
        end
        sgn = sgn & ~uns_q;
        merged = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            merged[8*i +: 8] = (4'(i) < cur_nbytes) ? merge_sh[8*i +: 8] : {8{sgn}};
        end
    end

    // Next-state logic: request capture, beat sequencing and result handshake.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        msize_d      = msize_q;
        uns_d        = uns_q;
        split_d      = split_q;
        lo_d         = lo_q;
        dreq_addr_d  = dreq_addr_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    off_d   = req_off;
                    msize_d = req_msize_i;
                    uns_d   = req_unsigned_i;
                    split_d = req_split;
                    if (req_size_err || req_align_err) begin
                        resp_error_d = 1'b1;
                        resp_data_d  = '0;
                        state_d      = StResp;
                    end else begin
                        resp_error_d = 1'b0;
                        dreq_addr_d  = req_base;
                        state_d      = StBeat0;
                    end
                end
            end
            StBeat0: begin
                if (dresp_data_ok_i) begin
                    lo_d = dresp_data_i;
                    if (split_q) begin
                        // Address wraps naturally at the top of the address space.
                        dreq_addr_d = dreq_addr_q + ADDR_W'(BYTES);
                        state_d     = StBeat1;
                    end else begin
                        resp_data_d = merged;
                        state_d     = StResp;
                    end
                end
            end
            StBeat1: begin
                if (dresp_data_ok_i) begin
                    resp_data_d = merged;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            off_q        <= '0;
            msize_q      <= '0;
            uns_q        <= 1'b0;
            split_q      <= 1'b0;
            lo_q         <= '0;
            dreq_addr_q  <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            msize_q      <= msize_d;
            uns_q        <= uns_d;
            split_q      <= split_d;
            lo_q         <= lo_d;
            dreq_addr_q  <= dreq_addr_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign dreq_valid_o = (state_q == StBeat0) || (state_q == StBeat1);
    assign dreq_addr_o  = dreq_addr_q;
    assign resp_valid_o = (state_q == StResp);
    assign resp_data_o  = resp_data_q;
    assign resp_error_o = resp_error_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: instance 0 splits bus-crossing loads, instance 1 rejects
// misaligned loads. Directed cases plus random loads checked against a byte-level model.
module tb_load_align_unit;

    logic clk = 1'b0;
    logic reset;

    logic [1:0]       req_valid, req_unsigned, dresp_ok, resp_ready;
    logic [1:0][63:0] req_addr, dresp_data;
    logic [1:0][1:0]  req_msize;
    logic [1:0]       req_ready, dreq_valid, resp_valid, resp_error;
    logic [1:0][63:0] dreq_addr, resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_align_unit #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(1'b1)) u_dut0 (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .req_msize_i(req_msize[0]), .req_unsigned_i(req_unsigned[0]),
        .dreq_valid_o(dreq_valid[0]), .dreq_addr_o(dreq_addr[0]),
        .dresp_data_ok_i(dresp_ok[0]), .dresp_data_i(dresp_data[0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_data_o(resp_data[0]), .resp_error_o(resp_error[0])
    );

    load_align_unit #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(1'b0)) u_dut1 (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .req_msize_i(req_msize[1]), .req_unsigned_i(req_unsigned[1]),
        .dreq_valid_o(dreq_valid[1]), .dreq_addr_o(dreq_addr[1]),
        .dresp_data_ok_i(dresp_ok[1]), .dresp_data_i(dresp_data[1]),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_data_o(resp_data[1]), .resp_error_o(resp_error[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick nb bytes starting at byte 'off' of the 16-byte window {hi, lo}.
    function automatic logic [63:0] ref_load(input logic [63:0] addr, input int nb,
                                             input bit uns, input logic [63:0] lo,
                                             input logic [63:0] hi);
        logic [7:0]  mem [16];
        logic [63:0] v;
        int          off;
        for (int i = 0; i < 8; i++) begin
            mem[i]     = lo[8*i +: 8];
            mem[i + 8] = hi[8*i +: 8];
        end
        off = int'(addr % 64'd8);
        v   = 64'd0;
        for (int i = 0; i < nb; i++) v = v + (64'(mem[off + i]) << (8 * i));
        if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
        return v;
    endfunction

    task automatic give_beat(input int u, input logic [63:0] data, input int stall,
                             input logic [63:0] exp_addr);
        repeat (stall) begin
            dresp_data[u] = {$urandom, $urandom};
            step();
            check_eq("stall_dreq_valid", 64'(dreq_valid[u]), 64'd1);
            check_eq("stall_dreq_addr", dreq_addr[u], exp_addr);
            check_eq("stall_req_ready", 64'(req_ready[u]), 64'd0);
        end
        dresp_ok[u]   = 1'b1;
        dresp_data[u] = data;
        step();
        dresp_ok[u]   = 1'b0;
        dresp_data[u] = {$urandom, $urandom};
    endtask

    task automatic do_load(input int u, input logic [63:0] addr, input logic [1:0] msize,
                           input bit uns, input logic [63:0] lo, input logic [63:0] hi,
                           input int st0, input int st1, input int bp,
                           output logic [63:0] got_data, output logic got_err);
        int          nb       = 1 << msize;
        int          off      = int'(addr % 64'd8);
        bit          exp_err  = (u == 1) && ((off % nb) != 0);
        bit          split    = !exp_err && (off + nb > 8);
        logic [63:0] base     = addr - 64'(off);
        logic [63:0] exp_data = exp_err ? 64'd0 : ref_load(addr, nb, uns, lo, hi);

        check_eq("idle_req_ready", 64'(req_ready[u]), 64'd1);
        req_valid[u]    = 1'b1;
        req_addr[u]     = addr;
        req_msize[u]    = msize;
        req_unsigned[u] = uns;
        step();
        req_valid[u] = 1'b0;
        req_addr[u]  = {$urandom, $urandom};
        if (!exp_err) begin
            check_eq("beat0_valid", 64'(dreq_valid[u]), 64'd1);
            check_eq("beat0_addr", dreq_addr[u], base);
            give_beat(u, lo, st0, base);
            if (split) begin
                check_eq("beat1_valid", 64'(dreq_valid[u]), 64'd1);
                check_eq("beat1_addr", dreq_addr[u], base + 64'd8);
                give_beat(u, hi, st1, base + 64'd8);
            end
        end
        check_eq("resp_valid", 64'(resp_valid[u]), 64'd1);
        check_eq("resp_error", 64'(resp_error[u]), 64'(exp_err));
        check_eq("resp_data", resp_data[u], exp_data);
        check_eq("resp_dreq_valid", 64'(dreq_valid[u]), 64'd0);
        got_data = resp_data[u];
        got_err  = resp_error[u];
        repeat (bp) begin
            step();
            check_eq("bp_resp_valid", 64'(resp_valid[u]), 64'd1);
            check_eq("bp_resp_data", resp_data[u], exp_data);
            check_eq("bp_req_ready", 64'(req_ready[u]), 64'd0);
        end
        resp_ready[u] = 1'b1;
        step();
        resp_ready[u] = 1'b0;
        check_eq("post_resp_valid", 64'(resp_valid[u]), 64'd0);
        check_eq("post_req_ready", 64'(req_ready[u]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        logic        e;
        reset        = 1'b1;
        req_valid    = '0;
        req_unsigned = '0;
        dresp_ok     = '0;
        resp_ready   = '0;
        req_addr     = '0;
        req_msize    = '0;
        dresp_data   = '0;
        step();
        step();
        for (int u = 0; u < 2; u++) begin
            check_eq("rst_req_ready", 64'(req_ready[u]), 64'd1);
            check_eq("rst_dreq_valid", 64'(dreq_valid[u]), 64'd0);
            check_eq("rst_dreq_addr", dreq_addr[u], 64'd0);
            check_eq("rst_resp_valid", 64'(resp_valid[u]), 64'd0);
            check_eq("rst_resp_data", resp_data[u], 64'd0);
            check_eq("rst_resp_error", 64'(resp_error[u]), 64'd0);
        end
        reset = 1'b0;
        step();

        // Directed cases with literal expectations.
        do_load(0, 64'h1003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'd0, 0, 0, 0, d, e);
        check_eq("tp_lb_signed", d, 64'hFFFF_FFFF_FFFF_FF80);
        do_load(0, 64'h2004, 2'd2, 1'b1, 64'h9ABC_DEF0_1234_5678, 64'd0, 0, 0, 0, d, e);
        check_eq("tp_lwu", d, 64'h0000_0000_9ABC_DEF0);
        check_eq("tp_lwu_err", 64'(e), 64'd0);
        do_load(0, 64'h3006, 2'd3, 1'b0, 64'h2222_1111_0000_0000, 64'h0000_0000_0000_4433,
                0, 0, 0, d, e);
        check_eq("tp_split_ld", d, 64'h0000_0000_4433_2222);
        do_load(1, 64'h4001, 2'd1, 1'b0, 64'd0, 64'd0, 0, 0, 0, d, e);
        check_eq("tp_misaligned_err", 64'(e), 64'd1);
        check_eq("tp_misaligned_data", d, 64'd0);
        do_load(0, 64'h5002, 2'd1, 1'b1, 64'h0000_0000_BEEF_0000, 64'd0, 5, 0, 3, d, e);
        check_eq("tp_stall_bp", d, 64'h0000_0000_0000_BEEF);
        // Second beat address wraps to zero.
        do_load(0, 64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 1'b0, 64'h8765_4321_0000_0000,
                64'h0000_0000_CAFE_F00D, 1, 2, 1, d, e);
        check_eq("tp_wrap", d, 64'hCAFE_F00D_8765_4321);

        // Reset during the second beat of a split load, then a stray data_ok.
        req_valid[0] = 1'b1; req_addr[0] = 64'h3006; req_msize[0] = 2'd3;
        req_unsigned[0] = 1'b0;
        step();
        req_valid[0] = 1'b0;
        give_beat(0, 64'h1234_5678_9ABC_DEF0, 0, 64'h3000);
        check_eq("rst_mid_beat1", dreq_addr[0], 64'h3008);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rst_mid_dreq_valid", 64'(dreq_valid[0]), 64'd0);
        check_eq("rst_mid_req_ready", 64'(req_ready[0]), 64'd1);
        check_eq("rst_mid_resp_valid", 64'(resp_valid[0]), 64'd0);
        dresp_ok[0] = 1'b1; dresp_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        dresp_ok[0] = 1'b0;
        repeat (2) begin
            check_eq("stray_resp_valid", 64'(resp_valid[0]), 64'd0);
            check_eq("stray_dreq_valid", 64'(dreq_valid[0]), 64'd0);
            check_eq("stray_req_ready", 64'(req_ready[0]), 64'd1);
            step();
        end

        // Random loads on both instances.
        for (int n = 0; n < 60; n++) begin
            int u;
            u = int'($urandom_range(0, 1));
            do_load(u, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), d, e);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
